// File: rtl/stack_sequencer.sv
// Command sequencer for the calculator's shift-register stack: turns opcodes into
// push/pop/swap strobes, tracks depth, rejects over/underflow and runs ADD/SUB/CLR.
module stack_sequencer #(
  parameter int STACK_SIZE = 8,
  parameter int WORD_W     = 4,
  localparam int DEPTH_W   = $clog2(STACK_SIZE + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_op,
  input  logic [WORD_W-1:0]  cmd_imm,
  input  logic [WORD_W-1:0]  top_word,
  input  logic [WORD_W-1:0]  second_word,
  output logic               stk_mode,
  output logic               stk_move,
  output logic               stk_swap,
  output logic [WORD_W-1:0]  stk_word,
  output logic [DEPTH_W-1:0] depth,
  output logic               empty,
  output logic               full,
  output logic               done,
  output logic               err,
  output logic               carry
);

  typedef enum logic [2:0] {IDLE, STEP, POP1, POP2, PUSHR, CLEAR, ERR} state_t;
  typedef enum logic [2:0] {
    OP_NOP, OP_PUSH, OP_POP, OP_SWAP, OP_DUP, OP_ADD, OP_SUB, OP_CLR
  } op_t;

  localparam logic [DEPTH_W-1:0] DEPTH_FULL = DEPTH_W'(STACK_SIZE);
  localparam logic [DEPTH_W-1:0] DEPTH_ONE  = DEPTH_W'(1);
  localparam logic [DEPTH_W-1:0] DEPTH_TWO  = DEPTH_W'(2);

  state_t              state;
  op_t                 op;
  logic                reject;
  logic [WORD_W-1:0]   result;
  logic [WORD_W:0]     sum;
  logic [WORD_W-1:0]   diff;

  assign op        = op_t'(cmd_op);
  assign cmd_ready = (state == IDLE);
  assign empty     = (depth == '0);
  assign full      = (depth == DEPTH_FULL);
  // a = second_word, b = top_word; both are stable while IDLE.
  assign sum       = {1'b0, second_word} + {1'b0, top_word};
  assign diff      = second_word - top_word;

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    reject = 1'b0;
    case (op)
      OP_PUSH, OP_DUP:        reject = full;
      OP_POP:                 reject = empty;
      OP_SWAP, OP_ADD, OP_SUB: reject = (depth < DEPTH_TWO);
      default:                reject = 1'b0;
    endcase
  end

  // NOTE: state and outputs use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      depth    <= '0;
      carry    <= 1'b0;
      result   <= '0;
      stk_mode <= 1'b0;
      stk_move <= 1'b0;
      stk_swap <= 1'b0;
      stk_word <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      stk_mode <= 1'b0;
      stk_move <= 1'b0;
      stk_swap <= 1'b0;
      stk_word <= '0;
      done     <= 1'b0;
      err      <= 1'b0;

      // Depth follows the strobe at the same edge the stack shifts.
      if (stk_move) depth <= stk_mode ? depth + DEPTH_ONE : depth - DEPTH_ONE;

      case (state)
        IDLE: begin
          if (cmd_valid) begin
            if (reject) begin
              state <= ERR;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              case (op)
                OP_NOP: begin
                  state <= STEP;
                  done  <= 1'b1;
                end
                OP_PUSH, OP_DUP: begin
                  state    <= STEP;
                  stk_move <= 1'b1;
                  stk_mode <= 1'b1;
                  stk_word <= (op == OP_PUSH) ? cmd_imm : top_word;
                  done     <= 1'b1;
                end
                OP_POP: begin
                  state    <= STEP;
                  stk_move <= 1'b1;
                  done     <= 1'b1;
                end
                OP_SWAP: begin
                  state    <= STEP;
                  stk_swap <= 1'b1;
                  done     <= 1'b1;
                end
                OP_ADD, OP_SUB: begin
                  state    <= POP1;
                  stk_move <= 1'b1;
                  result   <= (op == OP_ADD) ? sum[WORD_W-1:0] : diff;
                  carry    <= (op == OP_ADD) ? sum[WORD_W] : (second_word < top_word);
                end
                default: begin
                  if (empty) begin
                    state <= STEP;
                    done  <= 1'b1;
                  end else begin
                    state    <= CLEAR;
                    stk_move <= 1'b1;
                    done     <= (depth == DEPTH_ONE);
                  end
                end
              endcase
            end
          end
        end
        POP1: begin
          state    <= POP2;
          stk_move <= 1'b1;
        end
        POP2: begin
          state    <= PUSHR;
          stk_move <= 1'b1;
          stk_mode <= 1'b1;
          stk_word <= result;
          done     <= 1'b1;
        end
        CLEAR: begin
          // depth still holds the pre-pop count during this cycle.
          if (depth > DEPTH_ONE) begin
            stk_move <= 1'b1;
            done     <= (depth == DEPTH_TWO);
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_sequencer.sv
// Self-checking bench for stack_sequencer: a behavioural stack answers the strobes,
// and a queue-based model predicts results, cycle counts and errors per command.
module tb_stack_sequencer;
  localparam int SS = 8;
  localparam int W  = 4;
  localparam int DW = $clog2(SS + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd_op = '0;
  logic [W-1:0]  cmd_imm = '0;
  logic [W-1:0]  top_word;
  logic [W-1:0]  second_word;
  logic          stk_mode, stk_move, stk_swap;
  logic [W-1:0]  stk_word;
  logic [DW-1:0] depth;
  logic          empty, full, done, err, carry;

  always #5 clk = ~clk;

  stack_sequencer #(.STACK_SIZE(SS), .WORD_W(W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_imm(cmd_imm), .top_word(top_word), .second_word(second_word),
    .stk_mode(stk_mode), .stk_move(stk_move), .stk_swap(stk_swap), .stk_word(stk_word),
    .depth(depth), .empty(empty), .full(full), .done(done), .err(err), .carry(carry)
  );

  // Stack the sequencer drives; index 0 is the top.
  logic [W-1:0] smem [SS];
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < SS; i++) smem[i] <= '0;
    end else if (stk_move && stk_mode) begin
      for (int i = 1; i < SS; i++) smem[i] <= smem[i-1];
      smem[0] <= stk_word;
    end else if (stk_move) begin
      for (int i = 0; i < SS - 1; i++) smem[i] <= smem[i+1];
      smem[SS-1] <= '0;
    end else if (stk_swap) begin
      smem[0] <= smem[1];
      smem[1] <= smem[0];
    end
  end
  assign top_word    = smem[0];
  assign second_word = smem[1];

  int accepts = 0;
  always @(posedge clk) if (rst && cmd_valid && cmd_ready) accepts <= accepts + 1;

  int total = 0;
  int bad   = 0;
  int mq[$];
  int mcarry = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle_state();
    check("depth", depth, mq.size());
    check("empty", empty, mq.size() == 0);
    check("full", full, mq.size() == SS);
    check("carry", carry, mcarry);
    check("ready", cmd_ready, 1);
    check("idle_quiet", {stk_move, stk_swap, stk_mode, done, err}, 0);
    if (mq.size() >= 1) check("top", top_word, mq[0]);
    if (mq.size() >= 2) check("second", second_word, mq[1]);
  endtask

  task automatic run_cmd(input int op, input int imm);
    int e_err = 0, e_cyc = 1, e_push = 0, e_pop = 0, e_swap = 0;
    int a, b, r;
    int cyc = 0, npush = 0, npop = 0, nswap = 0, both = 0, early_err = 0;
    logic got_done = 1'b0, got_err = 1'b0;
    int sz = mq.size();
    case (op)
      1: if (sz == SS) e_err = 1; else begin mq.push_front(imm); e_push = 1; end
      2: if (sz == 0) e_err = 1; else begin void'(mq.pop_front()); e_pop = 1; end
      3: if (sz < 2) e_err = 1; else begin a = mq[0]; mq[0] = mq[1]; mq[1] = a; e_swap = 1; end
      4: if (sz == SS) e_err = 1; else begin mq.push_front(mq[0]); e_push = 1; end
      5, 6: if (sz < 2) e_err = 1; else begin
        b = mq.pop_front();
        a = mq.pop_front();
        if (op == 5) begin r = a + b; mcarry = (r >= 16) ? 1 : 0; end
        else begin r = a - b; mcarry = (a < b) ? 1 : 0; end
        mq.push_front((r + 16) % 16);
        e_cyc = 3; e_pop = 2; e_push = 1;
      end
      7: begin e_cyc = (sz == 0) ? 1 : sz; e_pop = sz; mq.delete(); end
      default: ;
    endcase

    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op[2:0];
    cmd_imm   = imm[W-1:0];
    for (int i = 0; i < 20 && !cmd_ready; i++) @(negedge clk);
    check("accept_ready", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc++;
      if (stk_move && stk_mode) npush++;
      else if (stk_move) npop++;
      if (stk_swap) nswap++;
      if (stk_move && stk_swap) both++;
      if (done) begin got_done = 1'b1; got_err = err; break; end
      if (err) early_err++;
      @(negedge clk);
    end
    check("done_seen", got_done, 1);
    check("exec_cycles", cyc, e_cyc);
    check("err", got_err, e_err);
    check("err_early", early_err, 0);
    check("push_strobes", npush, e_push);
    check("pop_strobes", npop, e_pop);
    check("swap_strobes", nswap, e_swap);
    check("move_and_swap", both, 0);
    @(negedge clk);
    check_idle_state();
  endtask

  initial begin
    int op, imm, acc0;

    // Reset and initial state
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_depth", depth, 0);
    check("rst_outs", {stk_move, stk_swap, stk_mode, stk_word, done, err, carry, full}, 0);
    check("rst_empty_ready", {empty, cmd_ready}, 2'b11);

    // 1: two pushes
    run_cmd(1, 3);
    run_cmd(1, 5);

    // 2: ADD with carry, SUB with borrow
    run_cmd(7, 0);
    run_cmd(1, 9);
    run_cmd(1, 9);
    run_cmd(5, 0);
    check("add_top", top_word, 2);
    check("add_carry", carry, 1);
    run_cmd(1, 3);
    run_cmd(1, 5);
    run_cmd(6, 0);
    check("sub_top", top_word, 14);

    // 3: underflows
    run_cmd(7, 0);
    run_cmd(7, 0);
    run_cmd(2, 0);
    run_cmd(1, 1);
    run_cmd(3, 0);
    run_cmd(5, 0);

    // 4: fill, DUP into last slot, overflow
    run_cmd(7, 0);
    for (int i = 0; i < 7; i++) run_cmd(1, i + 4);
    run_cmd(4, 0);
    check("dup_full", full, 1);
    check("dup_eq", top_word, second_word);
    run_cmd(1, 2);
    run_cmd(4, 0);

    // 5: CLR of four words
    run_cmd(7, 0);
    for (int i = 0; i < 4; i++) run_cmd(1, 12 - i);
    run_cmd(7, 0);

    // 6a: reset while ADD is in POP2
    run_cmd(1, 9);
    run_cmd(1, 9);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd5;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("pop2_move", {stk_move, stk_mode}, 2'b10);
    check("pop2_carry", carry, 1);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_outs", {stk_move, stk_swap, stk_mode, stk_word, done, err, carry}, 0);
    check("mid_rst_depth", depth, 0);
    rst = 1'b1;
    mq.delete();
    mcarry = 0;
    @(negedge clk);
    check_idle_state();

    // 6b: command held through a busy CLR is taken exactly once
    for (int i = 0; i < 4; i++) run_cmd(1, i);
    acc0 = accepts;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd7;
    @(negedge clk);
    cmd_op = 3'd1; cmd_imm = 4'd7;
    for (int i = 0; i < 20 && !cmd_ready; i++) @(negedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("held_accepts", accepts - acc0, 2);
    mq.delete();
    mq.push_front(7);
    check_idle_state();

    // Random commands against the model
    for (int n = 0; n < 300; n++) begin
      op  = $urandom_range(0, 7);
      imm = $urandom_range(0, 15);
      if (op == 4 && mq.size() == 0) op = 1;
      if (op == 7 && $urandom_range(0, 3) != 0) op = 1;
      run_cmd(op, imm);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
